// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding, fixed-latency data-memory responder with byte-enable RAM; define DMEM_MMIO_EN for CYCLE/SCRATCH registers
module dmem_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          READ_LAT  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2;

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
        $error("dmem_responder: READ_LAT must be in 1..4");
    end

    logic [31:0]   mem [DEPTH];
    logic [1:0]    state_q, state_d, cnt_q, cnt_d;
    logic          ready_q, ready_d, we_q, we_d, err_q, err_d, rsp_err_q, rsp_err_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d, rdata_q, rdata_d, word;
    logic [3:0]    be_q, be_d;
    logic [29:0]   off_w;
    logic          accept, fire, req_bad, wr;
`ifdef DMEM_MMIO_EN
    localparam logic [1:0] SEL_RAM = 2'd0, SEL_CYC = 2'd1, SEL_SCR = 2'd2;
    logic [1:0]  sel_q, sel_d, req_sel;
    logic [31:0] cycle_q, cycle_d, scratch_q, scratch_d;
`endif

    always_comb begin
        off_w     = 30'((req_addr - BASE_ADDR) >> 2);
        req_bad   = req_addr[1:0] != 2'b00 || off_w >= 30'(DEPTH);
        accept    = req_valid && ready_q;
        // fire marks the BUSY->RESP edge: RAM write and read-data capture
        fire      = state_q == BUSY && cnt_q == 2'd0;
        state_d   = accept ? BUSY : fire ? RESP : state_q == RESP ? IDLE : state_q;
        cnt_d     = accept ? 2'(READ_LAT - 1) : (state_q == BUSY && cnt_q != 2'd0) ? cnt_q - 2'd1 : cnt_q;
        ready_d   = state_d == IDLE;
        we_d      = accept ? req_we : we_q;
        idx_d     = accept ? off_w[AW-1:0] : idx_q;
        wdata_d   = accept ? req_wdata : wdata_q;
        be_d      = accept ? req_be : be_q;
`ifdef DMEM_MMIO_EN
        req_sel   = req_addr == 32'hFFFF_FF00 ? SEL_CYC : req_addr == 32'hFFFF_FF04 ? SEL_SCR : SEL_RAM;
        sel_d     = accept ? req_sel : sel_q;
        err_d     = accept ? (req_sel == SEL_CYC ? req_we : req_sel == SEL_SCR ? 1'b0 : req_bad) : err_q;
        word      = sel_q == SEL_CYC ? cycle_q : sel_q == SEL_SCR ? scratch_q : mem[idx_q];
        wr        = fire && we_q && !err_q && sel_q == SEL_RAM;
        cycle_d   = cycle_q + 32'd1;
        scratch_d = scratch_q;
        for (int i = 0; i < 4; i++)
            if (fire && we_q && !err_q && sel_q == SEL_SCR && be_q[i]) scratch_d[8*i +: 8] = wdata_q[8*i +: 8];
`else
        err_d     = accept ? req_bad : err_q;
        word      = mem[idx_q];
        wr        = fire && we_q && !err_q;
`endif
        rdata_d   = fire ? ((we_q || err_q) ? 32'd0 : word) : rdata_q;
        rsp_err_d = fire ? err_q : rsp_err_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            rdata_q   <= 32'd0;
            rsp_err_q <= 1'b0;
`ifdef DMEM_MMIO_EN
            sel_q     <= SEL_RAM;
            cycle_q   <= 32'd0;
            scratch_q <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            we_q      <= we_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            rsp_err_q <= rsp_err_d;
`ifdef DMEM_MMIO_EN
            sel_q     <= sel_d;
            cycle_q   <= cycle_d;
            scratch_q <= scratch_d;
`endif
        end
    end

    // RAM is never cleared by reset; a reset on the write edge suppresses the store
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (reset && wr && be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
    end

    assign req_ready = ready_q;
    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of a READ_LAT=1 and a READ_LAT=4 responder
module tb_dmem_responder;
    logic        clk = 1'b0, reset = 1'b0;
    logic        v1 = 1'b0, we1 = 1'b0, v4 = 1'b0, we4 = 1'b0;
    logic [31:0] a1 = 32'd0, w1 = 32'd0, a4 = 32'd0, w4 = 32'd0;
    logic [3:0]  be1 = 4'd0, be4 = 4'd0;
    logic        rdy1, rv1, er1, rdy4, rv4, er4;
    logic [31:0] rd1, rd4;
    int          pass = 0, total = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .READ_LAT(1), .BASE_ADDR(32'h0)) u1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
        .req_addr(a1), .req_wdata(w1), .req_be(be1),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(er1));

    dmem_responder #(.DEPTH(1024), .READ_LAT(4), .BASE_ADDR(32'h0)) u4 (
        .clk(clk), .reset(reset), .req_valid(v4), .req_ready(rdy4), .req_we(we4),
        .req_addr(a4), .req_wdata(w4), .req_be(be4),
        .rsp_valid(rv4), .rsp_rdata(rd4), .rsp_err(er4));

    // One request on instance s (0: READ_LAT=1, 1: READ_LAT=4); lat counts cycles from the accept cycle to rsp_valid
    task automatic req(input bit s, input logic we, input logic [31:0] a, input logic [31:0] w, input logic [3:0] be,
                       output logic [31:0] rd, output logic er, output int lat, output int busy);
        @(negedge clk);
        if (s) begin v4 = 1'b1; we4 = we; a4 = a; w4 = w; be4 = be; end
        else begin v1 = 1'b1; we1 = we; a1 = a; w1 = w; be1 = be; end
        @(negedge clk);
        v1 = 1'b0; v4 = 1'b0; we1 = ~we; we4 = ~we;
        a1 = 32'hFFFF_FFFC; a4 = 32'hFFFF_FFFC; w1 = 32'h0; w4 = 32'h0; be1 = 4'h0; be4 = 4'h0;
        lat = 1;
        busy = int'(!(s ? rdy4 : rdy1));
        while (!(s ? rv4 : rv1) && lat < 20) begin
            @(negedge clk);
            lat++;
            busy += int'(!(s ? rdy4 : rdy1));
        end
        rd = s ? rd4 : rd1;
        er = s ? er4 : er1;
    endtask

    task automatic test_reset();
        reset = 1'b0; v1 = 1'b1; v4 = 1'b1; we1 = 1'b0; we4 = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (rv1 !== 1'b0 || rdy1 !== 1'b0) $display("FAIL reset_hold cyc%0d rsp_valid=%b req_ready=%b exp 0 0", i, rv1, rdy1); else pass++;
        end
        reset = 1'b1; v1 = 1'b0; v4 = 1'b0;
        @(negedge clk);
        total++; if (rdy1 !== 1'b1 || rdy4 !== 1'b1) $display("FAIL reset_release req_ready=%b/%b exp 1/1", rdy1, rdy4); else pass++;
        total++; if (rd1 !== 32'd0 || er1 !== 1'b0 || rv1 !== 1'b0) $display("FAIL reset_outputs rdata=%h err=%b valid=%b exp 0", rd1, er1, rv1); else pass++;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat, busy;
        req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, busy);
        total++; if (lat !== 2 || er !== 1'b0) $display("FAIL store_rsp lat=%0d err=%b exp 2 0", lat, er); else pass++;
        total++; if (busy !== 2) $display("FAIL store_ready_low cycles=%0d exp 2", busy); else pass++;
        @(negedge clk);
        total++; if (rv1 !== 1'b0 || rdy1 !== 1'b1) $display("FAIL strobe_one_cycle rsp_valid=%b req_ready=%b exp 0 1", rv1, rdy1); else pass++;
        req(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, busy);
        total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) $display("FAIL load_data got %h err=%b exp deadbeef 0", rd, er); else pass++;
        total++; if (lat !== 2 || busy !== 2) $display("FAIL load_latency lat=%0d busy=%0d exp 2 2", lat, busy); else pass++;
    endtask

    task automatic test_partial_write();
        logic [31:0] rd; logic er; int lat, busy;
        req(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er, lat, busy);
        req(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, busy);
        total++; if (rd !== 32'hDE22BE44) $display("FAIL partial_write got %h exp de22be44", rd); else pass++;
        req(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat, busy);
        total++; if (er !== 1'b0 || rd !== 32'd0) $display("FAIL be_zero_ack err=%b rdata=%h exp 0 0", er, rd); else pass++;
        req(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, busy);
        total++; if (rd !== 32'hDE22BE44) $display("FAIL be_zero_nowrite got %h exp de22be44", rd); else pass++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat, busy;
        req(0, 1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat, busy);
        total++; if (er !== 1'b1 || rd !== 32'd0) $display("FAIL misaligned err=%b rdata=%h exp 1 0", er, rd); else pass++;
        req(0, 1'b1, 32'h0, 32'h12345678, 4'hF, rd, er, lat, busy);
        req(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, er, lat, busy);
        total++; if (er !== 1'b1) $display("FAIL out_of_range err=%b exp 1", er); else pass++;
        req(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, busy);
        total++; if (rd !== 32'h12345678 || er !== 1'b0) $display("FAIL oor_no_write got %h err=%b exp 12345678 0", rd, er); else pass++;
        req(0, 1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, rd, er, lat, busy);
        total++; if (er !== 1'b0) $display("FAIL last_word_store err=%b exp 0", er); else pass++;
        req(0, 1'b0, 32'hFFC, 32'h0, 4'h0, rd, er, lat, busy);
        total++; if (rd !== 32'hCAFEF00D) $display("FAIL last_word_load got %h exp cafef00d", rd); else pass++;
    endtask

    task automatic test_lat4();
        logic [31:0] rd; logic er; int lat, busy; logic seen;
        req(1, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, rd, er, lat, busy);
        total++; if (lat !== 5 || er !== 1'b0) $display("FAIL lat4_store lat=%0d err=%b exp 5 0", lat, er); else pass++;
        req(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, busy);
        total++; if (rd !== 32'h0BADF00D || lat !== 5 || busy !== 5) $display("FAIL lat4_load got %h lat=%0d busy=%0d exp 0badf00d 5 5", rd, lat, busy); else pass++;
        @(negedge clk);
        v4 = 1'b1; we4 = 1'b1; a4 = 32'h20; w4 = 32'h55555555; be4 = 4'hF;
        @(negedge clk);
        v4 = 1'b0; seen = rv4;
        @(negedge clk);
        reset = 1'b0; seen |= rv4;
        @(negedge clk);
        reset = 1'b1; seen |= rv4;
        @(negedge clk);
        total++; if (rdy4 !== 1'b1) $display("FAIL lat4_ready_after_reset req_ready=%b exp 1", rdy4); else pass++;
        for (int i = 0; i < 8; i++) begin seen |= rv4; @(negedge clk); end
        total++; if (seen !== 1'b0) $display("FAIL lat4_dropped rsp_valid_seen=%b exp 0", seen); else pass++;
        req(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, busy);
        total++; if (rd !== 32'h0BADF00D) $display("FAIL lat4_store_dropped got %h exp 0badf00d", rd); else pass++;
    endtask

    task automatic test_mmio();
        logic [31:0] rd, c0; logic er; int lat, busy;
`ifdef DMEM_MMIO_EN
        req(0, 1'b0, 32'hFFFF_FF00, 32'h0, 4'h0, c0, er, lat, busy);
        req(0, 1'b0, 32'hFFFF_FF00, 32'h0, 4'h0, rd, er, lat, busy);
        total++; if (rd - c0 !== 32'd3) $display("FAIL mmio_cycle_delta got %0d exp 3", rd - c0); else pass++;
        req(0, 1'b1, 32'hFFFF_FF04, 32'hA5A5A5A5, 4'hF, rd, er, lat, busy);
        total++; if (er !== 1'b0) $display("FAIL mmio_scratch_store err=%b exp 0", er); else pass++;
        req(0, 1'b0, 32'hFFFF_FF04, 32'h0, 4'h0, rd, er, lat, busy);
        total++; if (rd !== 32'hA5A5A5A5) $display("FAIL mmio_scratch_load got %h exp a5a5a5a5", rd); else pass++;
        req(0, 1'b1, 32'hFFFF_FF00, 32'h1, 4'hF, rd, er, lat, busy);
        total++; if (er !== 1'b1) $display("FAIL mmio_cycle_store err=%b exp 1", er); else pass++;
`else
        req(0, 1'b0, 32'hFFFF_FF00, 32'h0, 4'h0, c0, er, lat, busy);
        total++; if (er !== 1'b1 || c0 !== 32'd0) $display("FAIL mmio_off_cycle err=%b rdata=%h exp 1 0", er, c0); else pass++;
        req(0, 1'b1, 32'hFFFF_FF04, 32'hA5A5A5A5, 4'hF, rd, er, lat, busy);
        total++; if (er !== 1'b1) $display("FAIL mmio_off_scratch err=%b exp 1", er); else pass++;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_partial_write();
        test_errors();
        test_lat4();
        test_mmio();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
